micro_hash_miner: RTL and testbench
===================================

MICRO_HASH_MINER -- requirements
Module: micro_hash_miner

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 32, giving the compression rounds per attempt; legal range is 16..64.
REQ-002 The block SHALL have parameter SPLIT, default 17, the first round index that uses the OR/0xA1 phase.
REQ-003 The block SHALL have parameter CMP_BYTES, default 2, the number of hash bytes compared against target; legal range is 1..3.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request; SHALL be honoured only in IDLE.
REQ-007 abort  input  1  cancels the search in progress.
REQ-008 entry  input  12x8  payload bytes, sampled on start.
REQ-009 nonce_start  input  32  first nonce, sampled on start.
REQ-010 max_tries  input  16  attempt budget, sampled on start; a value of 0 SHALL be treated as 1.
REQ-011 target  input  8  difficulty threshold, sampled on start.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse marking the end of a search.
REQ-014 found  output  1  success flag, valid from done until the next accepted start.
REQ-015 nonce_out  output  32  winning nonce, or the last nonce tried.
REQ-016 hash_out  output  3x8  {H2,H1,H0} for the nonce_out attempt.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, EXPAND, ROUND, FINAL, DONE.
REQ-018 IDLE with start=1 SHALL:
- go to LOAD;
- capture entry, nonce_start, target and max_tries;
- clear found, tries and nonce_out.
REQ-019 LOAD (1 cycle) SHALL:
- set W[i]=entry[i] for i=0..11 and W[12+j]=nonce byte j (LSB first);
- set a=0x01, b=0x89, c=0xFE and t=0;
- go to EXPAND.
REQ-020 EXPAND SHALL compute one word per cycle for i=16..ROUNDS-1 as W[i]=W[i-3] | (W[i-9] ^ W[i-14]), 8-bit; it SHALL then go to ROUND.
REQ-021 ROUND SHALL perform one round per cycle for t=0..ROUNDS-1:
- t<SPLIT: x=a^b, k=0x99; otherwise x=a|b, k=0xA1;
- a'=b^c, b'=(c<<4) truncated to 8 bits, c'=x+k+W[t] mod 256.
REQ-022 After round ROUNDS-1 the FSM SHALL go to FINAL.
REQ-023 FINAL SHALL:
- form H0=0x01+a, H1=0x89+b, H2=0xFE+c (mod 256);
- load hash_out and nonce_out with the current attempt;
- increment tries.
REQ-024 FINAL SHALL declare a hit when every compared byte H0..H(CMP_BYTES-1) is strictly less than target.
REQ-025 On a hit, or when tries equals max_tries, FINAL SHALL set found to the hit result and go to DONE.
REQ-026 Otherwise FINAL SHALL increment the nonce (32-bit wrap, 0xFFFFFFFF to 0x00000000) and go to LOAD.
REQ-027 Per-attempt latency SHALL be exactly 2*ROUNDS-14 cycles, counting LOAD through FINAL (50 cycles at defaults).
REQ-028 DONE SHALL assert done for one cycle and return to IDLE.
REQ-029 In DONE, hash_out, nonce_out and found SHALL hold until the next accepted start.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort in any busy state SHALL:
- return the FSM to IDLE on the next edge;
- leave done unasserted;
- clear found;
- leave hash_out and nonce_out holding the last completed attempt.
REQ-032 abort and start together in IDLE SHALL be resolved with abort winning: no search starts.
REQ-033 Input changes after the start cycle SHALL NOT affect the search in progress.

Reset
REQ-034 reset=0 at a rising edge SHALL force IDLE and clear busy, done, found, nonce_out, hash_out, W, a, b, c, t and tries, including mid-search.
REQ-035 After reset is released, the block SHALL accept a start on the first following edge.

Verification
REQ-036 Reset mid-ROUND -> the next cycle shows busy=0, done=0, found=0, hash_out=0, nonce_out=0.
REQ-037 entry=0x00..0x0B, nonce_start=0, target=0x00, max_tries=3 -> nonce_out=0x00000002, done exactly 150 cycles after start, found=0, hash_out equal to the golden model.
REQ-038 Same entry, target=0xFF, max_tries=1000 -> found=1 at the first nonce whose compared bytes are all <0xFF, with nonce_out and hash_out matching the golden model.
REQ-039 nonce_start=0xFFFFFFFF, target=0x00, max_tries=2 -> second attempt uses nonce 0x00000000, so nonce_out=0x00000000 and found=0.
REQ-040 abort asserted 20 cycles after start -> busy=0 on the next cycle, no done pulse, found=0.
REQ-041 start pulsed while busy, then max_tries=0 -> extra start ignored; max_tries=0 runs exactly one attempt and pulses done 50 cycles after start.
REQ-042 ROUNDS=16 and ROUNDS=64 builds -> EXPAND skipped or 48 cycles respectively, with hashes matching the golden model.

Source files
------------

// File: rtl/micro_hash_miner.sv
// Nonce-search engine around a small 3-byte compression function.
// Each attempt runs LOAD, EXPAND, ROUND and FINAL. The search ends on a hit, when the budget runs out, or on abort.
module micro_hash_miner #(
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned SPLIT     = 17,
  parameter int unsigned CMP_BYTES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [11:0][7:0] entry,
  input  logic [31:0]      nonce_start,
  input  logic [15:0]      max_tries,
  input  logic [7:0]       target,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [31:0]      nonce_out,
  output logic [23:0]      hash_out
);

  localparam int unsigned IW = $clog2(ROUNDS);
  localparam logic [IW-1:0] LastIdx  = IW'(ROUNDS - 1);
  localparam logic [IW-1:0] FirstExp = IW'(16);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StExpand,
    StRound,
    StFinal,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [11:0][7:0]        entry_q, entry_d;
  logic [31:0]             nonce_q, nonce_d;
  logic [7:0]              target_q, target_d;
  logic [15:0]             max_q, max_d;
  logic [15:0]             tries_q, tries_d;
  logic [ROUNDS-1:0][7:0]  w_q, w_d;
  logic [7:0]              a_q, a_d, b_q, b_d, c_q, c_d;
  logic [IW-1:0]           t_q, t_d, i_q, i_d;
  logic                    found_q, found_d;
  logic [31:0]             nonce_out_q, nonce_out_d;
  logic [23:0]             hash_q, hash_d;

  logic [2:0][7:0] h;
  logic            hit;
  logic [7:0]      x, k;

  always_comb begin
    h   = {8'hFE + c_q, 8'h89 + b_q, 8'h01 + a_q};
    hit = 1'b1;
    for (int unsigned n = 0; n < 3; n++) begin
      if (n < CMP_BYTES && h[n] >= target_q) hit = 1'b0;
    end
    if (32'(t_q) < SPLIT) begin
      x = a_q ^ b_q;
      k = 8'h99;
    end else begin
      x = a_q | b_q;
      k = 8'hA1;
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    nonce_d     = nonce_q;
    target_d    = target_q;
    max_d       = max_q;
    tries_d     = tries_q;
    w_d         = w_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    t_d         = t_q;
    i_d         = i_q;
    found_d     = found_q;
    nonce_out_d = nonce_out_q;
    hash_d      = hash_q;

    // Abort beats every other action, and leaves the last completed attempt visible.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      found_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d     = StLoad;
            entry_d     = entry;
            nonce_d     = nonce_start;
            target_d    = target;
            max_d       = (max_tries == 16'd0) ? 16'd1 : max_tries;
            found_d     = 1'b0;
            tries_d     = 16'd0;
            nonce_out_d = 32'd0;
          end
        end
        StLoad: begin
          for (int unsigned n = 0; n < 12; n++) w_d[n] = entry_q[n];
          for (int unsigned n = 0; n < 4; n++) w_d[12+n] = nonce_q[8*n +: 8];
          a_d     = 8'h01;
          b_d     = 8'h89;
          c_d     = 8'hFE;
          t_d     = '0;
          i_d     = FirstExp;
          state_d = (ROUNDS > 16) ? StExpand : StRound;
        end
        StExpand: begin
          w_d[i_q] = w_q[i_q - IW'(3)] | (w_q[i_q - IW'(9)] ^ w_q[i_q - IW'(14)]);
          if (i_q == LastIdx) state_d = StRound;
          else                i_d     = i_q + 1'b1;
        end
        StRound: begin
          a_d = b_q ^ c_q;
          b_d = {c_q[3:0], 4'h0};
          c_d = x + k + w_q[t_q];
          if (t_q == LastIdx) state_d = StFinal;
          else                t_d     = t_q + 1'b1;
        end
        StFinal: begin
          hash_d      = h;
          nonce_out_d = nonce_q;
          tries_d     = tries_q + 16'd1;
          if (hit || tries_d == max_q) begin
            found_d = hit;
            state_d = StDone;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = StLoad;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      entry_q     <= '0;
      nonce_q     <= '0;
      target_q    <= '0;
      max_q       <= '0;
      tries_q     <= '0;
      w_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      t_q         <= '0;
      i_q         <= '0;
      found_q     <= 1'b0;
      nonce_out_q <= '0;
      hash_q      <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      nonce_q     <= nonce_d;
      target_q    <= target_d;
      max_q       <= max_d;
      tries_q     <= tries_d;
      w_q         <= w_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      t_q         <= t_d;
      i_q         <= i_d;
      found_q     <= found_d;
      nonce_out_q <= nonce_out_d;
      hash_q      <= hash_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign found     = found_q;
  assign nonce_out = nonce_out_q;
  assign hash_out  = hash_q;

endmodule

// File: tb/tb_micro_hash_miner.sv
// Directed bench for micro_hash_miner; the default build is checked against a behavioural hash model.
// Separate 16- and 64-round instances are also checked against the same model.
module tb_micro_hash_miner;

  localparam int unsigned Split    = 17;
  localparam int unsigned CmpBytes = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, start_x, abort;
  logic [11:0][7:0] entry;
  logic [31:0]      nonce_start;
  logic [15:0]      max_tries;
  logic [7:0]       target;
  logic             busy, done, found;
  logic [31:0]      nonce_out;
  logic [23:0]      hash_out;
  logic             busy16, done16, found16, busy64, done64, found64;
  logic [31:0]      nonce16, nonce64;
  logic [23:0]      hash16, hash64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  micro_hash_miner u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .entry(entry),
    .nonce_start(nonce_start), .max_tries(max_tries), .target(target),
    .busy(busy), .done(done), .found(found), .nonce_out(nonce_out), .hash_out(hash_out)
  );

  micro_hash_miner #(.ROUNDS(16)) u_r16 (
    .clk(clk), .reset(reset), .start(start_x), .abort(abort), .entry(entry),
    .nonce_start(nonce_start), .max_tries(max_tries), .target(target),
    .busy(busy16), .done(done16), .found(found16), .nonce_out(nonce16), .hash_out(hash16)
  );

  micro_hash_miner #(.ROUNDS(64)) u_r64 (
    .clk(clk), .reset(reset), .start(start_x), .abort(abort), .entry(entry),
    .nonce_start(nonce_start), .max_tries(max_tries), .target(target),
    .busy(busy64), .done(done64), .found(found64), .nonce_out(nonce64), .hash_out(hash64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_hash(input int unsigned rounds,
                                             input logic [11:0][7:0] e, input logic [31:0] n);
    logic [7:0] w [64];
    logic [7:0] a, b, c, x, k, na, nb;
    for (int i = 0; i < 12; i++) w[i] = e[i];
    for (int j = 0; j < 4; j++) w[12+j] = n[8*j +: 8];
    for (int i = 16; i < int'(rounds); i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01;
    b = 8'h89;
    c = 8'hFE;
    for (int t = 0; t < int'(rounds); t++) begin
      if (t < int'(Split)) begin x = a ^ b; k = 8'h99; end
      else                 begin x = a | b; k = 8'hA1; end
      na = b ^ c;
      nb = {c[3:0], 4'h0};
      c  = x + k + w[t];
      a  = na;
      b  = nb;
    end
    return {8'hFE + c, 8'h89 + b, 8'h01 + a};
  endfunction

  function automatic logic model_hit(input logic [23:0] h, input logic [7:0] tg);
    logic r = 1'b1;
    for (int i = 0; i < int'(CmpBytes); i++) if (h[8*i +: 8] >= tg) r = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [7:0] base);
    for (int i = 0; i < 12; i++) entry[i] = base + 8'(i);
  endtask

  task automatic launch(input logic [31:0] ns, input logic [15:0] mt, input logic [7:0] tg);
    nonce_start = ns;
    max_tries   = mt;
    target      = tg;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Edges from the call until done is seen; -1 if the budget expires.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!done && cycles < budget);
    if (!done) cycles = -1;
  endtask

  logic [11:0][7:0] e0;
  logic [23:0]      exp_h;
  int               cyc, hit_n, c16, c64;

  initial begin
    reset = 1'b0; start = 1'b0; start_x = 1'b0; abort = 1'b0;
    nonce_start = '0; max_tries = '0; target = '0;
    set_entry(8'h00);
    e0 = entry;
    tick(); tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_found", 64'(found), 64'd0);
    check_eq("rst_nonce", 64'(nonce_out), 64'd0);
    check_eq("rst_hash", 64'(hash_out), 64'd0);
    reset = 1'b1;

    // Three failing attempts; inputs are scrambled right after start.
    launch(32'd0, 16'd3, 8'h00);
    set_entry(8'hF0);
    nonce_start = 32'hDEAD_BEEF;
    target      = 8'hFF;
    max_tries   = 16'd1;
    wait_done(400, cyc);
    check_eq("t3_latency", 64'(cyc), 64'd150);
    check_eq("t3_found", 64'(found), 64'd0);
    check_eq("t3_nonce", 64'(nonce_out), 64'd2);
    check_eq("t3_hash", 64'(hash_out), 64'(model_hash(32, e0, 32'd2)));
    tick();
    check_eq("t3_done_pulse", 64'(done), 64'd0);
    check_eq("t3_idle", 64'(busy), 64'd0);
    check_eq("t3_nonce_hold", 64'(nonce_out), 64'd2);

    // Easy target: stop at first nonce whose compared bytes are below 0xFF.
    hit_n = 0;
    while (hit_n < 999 && !model_hit(model_hash(32, e0, 32'(hit_n)), 8'hFF)) hit_n++;
    set_entry(8'h00);
    launch(32'd0, 16'd1000, 8'hFF);
    wait_done(60000, cyc);
    check_eq("hit_latency", 64'(cyc), 64'(50 * (hit_n + 1)));
    check_eq("hit_found", 64'(found), 64'd1);
    check_eq("hit_nonce", 64'(nonce_out), 64'(hit_n));
    check_eq("hit_hash", 64'(hash_out), 64'(model_hash(32, e0, 32'(hit_n))));
    tick();
    check_eq("hit_found_hold", 64'(found), 64'd1);

    // Nonce wraps from all-ones to zero.
    launch(32'hFFFF_FFFF, 16'd2, 8'h00);
    wait_done(400, cyc);
    check_eq("wrap_latency", 64'(cyc), 64'd100);
    check_eq("wrap_nonce", 64'(nonce_out), 64'd0);
    check_eq("wrap_found", 64'(found), 64'd0);
    exp_h = model_hash(32, e0, 32'd0);
    check_eq("wrap_hash", 64'(hash_out), 64'(exp_h));
    tick();

    // Abort mid-search.
    launch(32'd5, 16'd4, 8'hFF);
    for (int i = 0; i < 20; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_found", 64'(found), 64'd0);
    check_eq("abort_hash_hold", 64'(hash_out), 64'(exp_h));
    cyc = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) cyc++;
    end
    check_eq("abort_quiet", 64'(cyc), 64'd0);

    // Abort and start together in idle: abort wins.
    abort = 1'b1;
    launch(32'd0, 16'd1, 8'hFF);
    abort = 1'b0;
    check_eq("abort_start_idle", 64'(busy), 64'd0);

    // Extra start while busy is ignored; max_tries=0 runs one attempt.
    set_entry(8'h40);
    e0 = entry;
    launch(32'h1234_5678, 16'd0, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    set_entry(8'h90);
    launch(32'h0000_AAAA, 16'd5, 8'hFF);
    wait_done(400, cyc);
    check_eq("mt0_latency", 64'(cyc + 6), 64'd50);
    check_eq("mt0_nonce", 64'(nonce_out), 64'h1234_5678);
    check_eq("mt0_hash", 64'(hash_out), 64'(model_hash(32, e0, 32'h1234_5678)));
    check_eq("mt0_found", 64'(found), 64'd0);
    tick();
    check_eq("mt0_idle", 64'(busy), 64'd0);

    // Reset in the middle of the round phase.
    launch(32'd9, 16'd5, 8'h00);
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b0;
    tick();
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_found", 64'(found), 64'd0);
    check_eq("midrst_hash", 64'(hash_out), 64'd0);
    check_eq("midrst_nonce", 64'(nonce_out), 64'd0);
    reset = 1'b1;

    // 16- and 64-round builds, started together on the first edge after reset.
    set_entry(8'h10);
    e0 = entry;
    nonce_start = 32'd7;
    max_tries   = 16'd1;
    target      = 8'h00;
    start_x     = 1'b1;
    tick();
    start_x     = 1'b0;
    c16 = -1;
    c64 = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done16 && c16 < 0) c16 = i;
      if (done64 && c64 < 0) begin
        c64 = i;
        break;
      end
    end
    check_eq("r16_latency", 64'(c16), 64'd18);
    check_eq("r64_latency", 64'(c64), 64'd114);
    check_eq("r16_hash", 64'(hash16), 64'(model_hash(16, e0, 32'd7)));
    check_eq("r64_hash", 64'(hash64), 64'(model_hash(64, e0, 32'd7)));
    check_eq("r16_nonce", 64'(nonce16), 64'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
